// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM state encoding and owner codes.
// Optional feature macro: MEM_ARB_MISALIGN_CHK_EN (see mem_arbiter.sv).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_IO  = 1'b1;

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: CPU port, IO port, memory side, status.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              CpuReq;
    logic              CpuWe;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWData;
    logic              CpuAck;
    logic [DATA_W-1:0] CpuRData;
    logic              CpuErr;

    logic              IoReq;
    logic              IoWe;
    logic [ADDR_W-1:0] IoAddr;
    logic [DATA_W-1:0] IoWData;
    logic              IoAck;
    logic [DATA_W-1:0] IoRData;

    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemRData;

    logic              Busy;
    logic              Owner;

    modport slave (
        input  CpuReq, CpuWe, CpuAddr, CpuWData,
        input  IoReq, IoWe, IoAddr, IoWData,
        input  MemRData,
        output CpuAck, CpuRData, CpuErr,
        output IoAck, IoRData,
        output MemAddr, MemWData, MemRead, MemWrite,
        output Busy, Owner
    );

    modport master (
        output CpuReq, CpuWe, CpuAddr, CpuWData,
        output IoReq, IoWe, IoAddr, IoWData,
        output MemRData,
        input  CpuAck, CpuRData, CpuErr,
        input  IoAck, IoRData,
        input  MemAddr, MemWData, MemRead, MemWrite,
        input  Busy, Owner
    );

endinterface

// File: rtl/mem_arb_prio.sv
// mem_arbiter winner selection: fixed CPU priority with an IO
// starvation counter that forces an IO win after STARVE_MAX losses.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic cpuReq,
    input  logic ioReq,
    input  logic grantEn,
    output logic anyReq,
    output logic ioWins
);
    import mem_arb_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starveCnt;
    logic          starved;

    assign starved = (starveCnt == SW'(STARVE_MAX));
    assign anyReq  = cpuReq | ioReq;
    assign ioWins  = ioReq & (~cpuReq | starved);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            starveCnt <= '0;
        end else if (grantEn && anyReq) begin
            if (ioWins)
                starveCnt <= '0;
            else if (ioReq && !starved)
                starveCnt <= starveCnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter, CPU vs IO, req/ack with read latency.
// Define MEM_ARB_MISALIGN_CHK_EN to abort odd-address CPU requests.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    mem_arbiter_if.slave  bus
);
    import mem_arb_pkg::*;

    localparam int LW = cntWidth(MEM_LAT);

    state_t            state;
    logic [LW-1:0]     latCnt;
    logic              weQ;
    logic              owner;
    logic              busy;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memRead;
    logic              memWrite;
    logic              cpuAck;
    logic              ioAck;
    logic              cpuErr;
    logic [DATA_W-1:0] cpuRData;
    logic [DATA_W-1:0] ioRData;

    logic              anyReq;
    logic              ioWins;
    logic              grantEn;
    logic              misalign;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWData;

    assign grantEn = (state == IDLE);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) uPrio (
        .CLK     (CLK),
        .Reset   (Reset),
        .cpuReq  (bus.CpuReq),
        .ioReq   (bus.IoReq),
        .grantEn (grantEn),
        .anyReq  (anyReq),
        .ioWins  (ioWins)
    );

    assign selWe    = ioWins ? bus.IoWe    : bus.CpuWe;
    assign selAddr  = ioWins ? bus.IoAddr  : bus.CpuAddr;
    assign selWData = ioWins ? bus.IoWData : bus.CpuWData;

`ifdef MEM_ARB_MISALIGN_CHK_EN
    assign misalign = ~ioWins & bus.CpuAddr[0];
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            latCnt   <= '0;
            weQ      <= 1'b0;
            owner    <= OWNER_CPU;
            busy     <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            cpuAck   <= 1'b0;
            ioAck    <= 1'b0;
            cpuErr   <= 1'b0;
            cpuRData <= '0;
            ioRData  <= '0;
        end else begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            cpuAck   <= 1'b0;
            ioAck    <= 1'b0;
            cpuErr   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner <= ioWins;
                        weQ   <= selWe;
                        busy  <= 1'b1;
                        if (misalign) begin
                            state  <= ACK;
                            cpuAck <= 1'b1;
                            cpuErr <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            memAddr  <= selAddr;
                            memWData <= selWData;
                            memWrite <= selWe;
                            memRead  <= ~selWe;
                        end
                    end
                end
                ISSUE: begin
                    if (weQ) begin
                        state  <= ACK;
                        cpuAck <= (owner == OWNER_CPU);
                        ioAck  <= (owner == OWNER_IO);
                    end else begin
                        state  <= WAIT;
                        latCnt <= LW'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (latCnt == '0) begin
                        state <= ACK;
                        if (owner == OWNER_IO) begin
                            ioRData <= bus.MemRData;
                            ioAck   <= 1'b1;
                        end else begin
                            cpuRData <= bus.MemRData;
                            cpuAck   <= 1'b1;
                        end
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MemAddr  = memAddr;
    assign bus.MemWData = memWData;
    assign bus.MemRead  = memRead;
    assign bus.MemWrite = memWrite;
    assign bus.CpuAck   = cpuAck;
    assign bus.CpuRData = cpuRData;
    assign bus.CpuErr   = cpuErr;
    assign bus.IoAck    = ioAck;
    assign bus.IoRData  = ioRData;
    assign bus.Busy     = busy;
    assign bus.Owner    = owner;

endmodule
